ro_sched: RTL and testbench

- Round-robin scheduler that shares one CORDIC rotation-mode unit among NUM_REQ requesters (column/element engines of the QR datapath).
- For each granted request it:
  - issues the (x, y) pair to the unit;
  - streams the requester's ITER_NUM direction bits on the unit's d channel, one per rotation cycle;
  - returns the scaled result tagged with the requester index.
- Sits between the vectoring-mode stage, which produces the direction vectors, and the rotation unit. Only one operation is in flight at a time, because the unit is iterative, not pipelined.

---
 rtl/ro_sched.sv | 190 +++++++++++++++++++
 tb/tb_ro_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_sched.sv
// Purpose : round-robin share of one iterative CORDIC rotation unit among NUM_REQ requesters.
// Latency : issue at t0, direction bits t0..t(ITER_NUM-1), tagged response at t(ITER_NUM+1).
// Backpres: one op in flight; requests hold their level until granted, never dropped.
//
// Ports:
//   i_clk, i_rst_n           clock (rising edge), synchronous active-low reset
//   i_req/_x/_y/_dvec        per-requester level request with packed operand and direction slices
//   o_gnt                    one-hot grant; request consumed when i_req[r] & o_gnt[r]
//   o_ro_data_valid/x/y      operand issue to the rotation unit
//   o_ro_d_valid/o_ro_d      per-iteration direction bit to the rotation unit
//   i_ro_data_valid/x/y      result from the rotation unit
//   o_resp_valid/id/x/y      result pulse tagged with owning requester
//   o_busy, o_err            op in flight, sticky protocol error
module ro_sched #(
    parameter int NUM_REQ     = 4,
    parameter int INOUT_WIDTH = 16,
    parameter int ITER_NUM    = 9,
    parameter int ID_W        = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*INOUT_WIDTH-1:0]  i_req_x,
    input  logic [NUM_REQ*INOUT_WIDTH-1:0]  i_req_y,
    input  logic [NUM_REQ*ITER_NUM-1:0]     i_req_dvec,
    output logic [NUM_REQ-1:0]              o_gnt,
    output logic                            o_ro_data_valid,
    output logic [INOUT_WIDTH-1:0]          o_ro_x,
    output logic [INOUT_WIDTH-1:0]          o_ro_y,
    output logic                            o_ro_d_valid,
    output logic                            o_ro_d,
    input  logic                            i_ro_data_valid,
    input  logic [INOUT_WIDTH-1:0]          i_ro_x,
    input  logic [INOUT_WIDTH-1:0]          i_ro_y,
    output logic                            o_resp_valid,
    output logic [ID_W-1:0]                 o_resp_id,
    output logic [INOUT_WIDTH-1:0]          o_resp_x,
    output logic [INOUT_WIDTH-1:0]          o_resp_y,
    output logic                            o_busy,
    output logic                            o_err
);

    localparam int CNT_W = $clog2(ITER_NUM + 1);

    typedef enum logic [1:0] {IDLE, ROT, SCALE, RESULT} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, rr_nxt;
    logic [ID_W-1:0]     id_q, id_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ITER_NUM-1:0] dvec_q, dvec_nxt;
    logic                err_q, err_nxt;

    // Unpacked views of the per-requester slices so selection uses a plain index.
    logic [INOUT_WIDTH-1:0] req_x_a    [NUM_REQ];
    logic [INOUT_WIDTH-1:0] req_y_a    [NUM_REQ];
    logic [ITER_NUM-1:0]    req_dvec_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_x_a[g]    = i_req_x[g*INOUT_WIDTH +: INOUT_WIDTH];
        assign req_y_a[g]    = i_req_y[g*INOUT_WIDTH +: INOUT_WIDTH];
        assign req_dvec_a[g] = i_req_dvec[g*ITER_NUM +: ITER_NUM];
    end

    // Round-robin pick: first set request at or after rr_ptr, wrapping.
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;

    always_comb begin
        int c;
        logic [ID_W-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        c         = 0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            cand = ID_W'(c);
            if (!gnt_found && i_req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    logic                   issue;
    logic [NUM_REQ-1:0]     gnt;
    logic                   ro_dv, d_v, d_bit, resp_v, busy;
    logic [INOUT_WIDTH-1:0] ro_x, ro_y;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dvec_nxt  = dvec_q;
        id_nxt    = id_q;
        rr_nxt    = rr_ptr;
        err_nxt   = err_q;
        issue     = 1'b0;
        gnt       = '0;
        ro_dv     = 1'b0;
        ro_x      = '0;
        ro_y      = '0;
        d_v       = 1'b0;
        d_bit     = 1'b0;
        resp_v    = 1'b0;
        busy      = 1'b0;

        case (state)
            IDLE: begin
                issue = gnt_found;
            end
            ROT: begin
                busy    = 1'b1;
                d_v     = 1'b1;
                d_bit   = dvec_q[cnt];
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_W'(ITER_NUM - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = SCALE;
                end
            end
            SCALE: begin
                busy      = 1'b1;
                state_nxt = RESULT;
            end
            RESULT: begin
                busy      = 1'b1;
                resp_v    = 1'b1;
                state_nxt = IDLE;
                if (!i_ro_data_valid) err_nxt = 1'b1;
                // Re-arbitrate now so a waiting requester issues with no bubble.
                issue = gnt_found;
            end
            default: state_nxt = IDLE;
        endcase

        if (i_ro_data_valid && state != RESULT) err_nxt = 1'b1;

        // Issue cycle: operands and the first direction bit go out together.
        if (issue) begin
            gnt       = NUM_REQ'(1) << gnt_idx;
            busy      = 1'b1;
            ro_dv     = 1'b1;
            ro_x      = req_x_a[gnt_idx];
            ro_y      = req_y_a[gnt_idx];
            d_v       = 1'b1;
            d_bit     = req_dvec_a[gnt_idx][0];
            dvec_nxt  = req_dvec_a[gnt_idx];
            id_nxt    = gnt_idx;
            rr_nxt    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = ROT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            dvec_q <= '0;
            id_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            cnt    <= cnt_nxt;
            dvec_q <= dvec_nxt;
            id_q   <= id_nxt;
            err_q  <= err_nxt;
        end
    end

    // Outputs are held at zero while reset is asserted so nothing leaks mid-reset.
    assign o_gnt           = i_rst_n ? gnt : '0;
    assign o_ro_data_valid = i_rst_n & ro_dv;
    assign o_ro_x          = i_rst_n ? ro_x : '0;
    assign o_ro_y          = i_rst_n ? ro_y : '0;
    assign o_ro_d_valid    = i_rst_n & d_v;
    assign o_ro_d          = i_rst_n & d_bit;
    assign o_resp_valid    = i_rst_n & resp_v;
    // Tag comes from the latched id, so a same-cycle re-issue cannot alter it.
    assign o_resp_id       = (i_rst_n && resp_v) ? id_q : '0;
    assign o_resp_x        = (i_rst_n && resp_v) ? i_ro_x : '0;
    assign o_resp_y        = (i_rst_n && resp_v) ? i_ro_y : '0;
    assign o_busy          = i_rst_n & busy;
    assign o_err           = i_rst_n & err_q;

endmodule

// File: tb/tb_ro_sched.sv
// Purpose : directed self-checking bench for ro_sched with a simple rotation-unit model.
// Latency : model returns the result 10 cycles after each operand issue.
// Backpres: none; stimulus is cycle-exact.
module tb_ro_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] req_x, req_y;
    logic [35:0] req_dvec;
    logic [3:0]  gnt;
    logic        ro_dv, ro_d_v, ro_d;
    logic [15:0] ro_x_o, ro_y_o;
    logic        ro_vld;
    logic [15:0] ro_x_i, ro_y_i;
    logic        resp_v, busy, err;
    logic [1:0]  resp_id;
    logic [15:0] resp_x, resp_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ro_sched dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req(req), .i_req_x(req_x), .i_req_y(req_y), .i_req_dvec(req_dvec),
        .o_gnt(gnt),
        .o_ro_data_valid(ro_dv), .o_ro_x(ro_x_o), .o_ro_y(ro_y_o),
        .o_ro_d_valid(ro_d_v), .o_ro_d(ro_d),
        .i_ro_data_valid(ro_vld), .i_ro_x(ro_x_i), .i_ro_y(ro_y_i),
        .o_resp_valid(resp_v), .o_resp_id(resp_id), .o_resp_x(resp_x), .o_resp_y(resp_y),
        .o_busy(busy), .o_err(err)
    );

    // Rotation-unit model: result strobe 10 cycles after issue, data = operands XOR a mask.
    logic [3:0]  mcnt;
    logic [15:0] cap_x, cap_y;
    logic        inject;

    always @(posedge clk) begin
        if (!rst_n) mcnt <= 4'd0;
        else if (ro_dv) begin
            mcnt  <= 4'd1;
            cap_x <= ro_x_o;
            cap_y <= ro_y_o;
        end else if (mcnt != 4'd0 && mcnt != 4'd10) mcnt <= mcnt + 4'd1;
        else mcnt <= 4'd0;
    end

    assign ro_vld = (mcnt == 4'd10) | inject;
    assign ro_x_i = cap_x ^ 16'h5A5A;
    assign ro_y_i = cap_y ^ 16'hA5A5;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 4'b1111; inject = 1'b0;
        req_x = '0; req_y = '0; req_dvec = '0;
        step; step;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (ro_dv !== 1'b0 || ro_d_v !== 1'b0) begin errors++; $display("FAIL reset_ro got %b%b exp 00", ro_dv, ro_d_v); end
        checks++; if (resp_v !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b%b exp 00", resp_v, err); end
        rst_n = 1'b1; req = 4'b0000;
        step;
    endtask

    task automatic test_single;
        req_x[32 +: 16] = 16'h2000; req_y[32 +: 16] = 16'h0000; req_dvec[18 +: 9] = 9'h1FF;
        for (int t = 0; t <= 11; t++) begin
            req = (t == 0) ? 4'b0100 : 4'b0000;
            #1;
            if (t == 0) begin
                checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
                checks++; if (ro_dv !== 1'b1 || ro_x_o !== 16'h2000 || ro_y_o !== 16'h0000) begin
                    errors++; $display("FAIL single_issue got v=%b x=%h y=%h exp v=1 x=2000 y=0000", ro_dv, ro_x_o, ro_y_o); end
            end
            if (t <= 8) begin
                checks++; if (ro_d_v !== 1'b1 || ro_d !== 1'b1) begin errors++; $display("FAIL single_d t%0d got %b%b exp 11", t, ro_d_v, ro_d); end
            end
            if (t == 5) begin
                checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_mid got gnt=%b busy=%b exp 0000 1", gnt, busy); end
            end
            if (t == 9) begin
                checks++; if (ro_d_v !== 1'b0 || busy !== 1'b1 || resp_v !== 1'b0) begin
                    errors++; $display("FAIL single_scale got dv=%b busy=%b rv=%b exp 0 1 0", ro_d_v, busy, resp_v); end
            end
            if (t == 10) begin
                checks++; if (resp_v !== 1'b1 || resp_id !== 2'd2) begin errors++; $display("FAIL single_resp got v=%b id=%0d exp v=1 id=2", resp_v, resp_id); end
                checks++; if (resp_x !== 16'h7A5A || resp_y !== 16'hA5A5) begin errors++; $display("FAIL single_data got %h %h exp 7a5a a5a5", resp_x, resp_y); end
            end
            if (t == 11) begin
                checks++; if (busy !== 1'b0 || resp_v !== 1'b0 || err !== 1'b0) begin
                    errors++; $display("FAIL single_end got busy=%b rv=%b err=%b exp 000", busy, resp_v, err); end
            end
            step;
        end
    endtask

    task automatic test_dstream;
        logic [8:0] bits;
        int n;
        bits = '0; n = 0;
        req_dvec[0 +: 9] = 9'b101010101;
        for (int t = 0; t <= 11; t++) begin
            req = (t == 0) ? 4'b0001 : 4'b0000;
            #1;
            if (ro_d_v === 1'b1) begin
                bits = {ro_d, bits[8:1]};
                n++;
            end
            if (t == 10) begin
                checks++; if (resp_v !== 1'b1 || resp_id !== 2'd0) begin errors++; $display("FAIL dstream_resp got v=%b id=%0d exp v=1 id=0", resp_v, resp_id); end
            end
            step;
        end
        checks++; if (n != 9) begin errors++; $display("FAIL dstream_count got %0d exp 9", n); end
        checks++; if (bits !== 9'b101010101) begin errors++; $display("FAIL dstream_bits got %b exp 101010101", bits); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  eg;
        logic [15:0] ex;
        int          r;
        rst_n = 1'b0; step; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) req_x[i*16 +: 16] = 16'h1000 * 16'(i + 1);
        for (int t = 0; t <= 50; t++) begin
            req = (t <= 40) ? 4'b1111 : 4'b0000;
            #1;
            if (t % 10 == 0 && t <= 40) begin
                eg = 4'b0001 << ((t / 10) % 4);
                checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt t%0d got %b exp %b", t, gnt, eg); end
            end
            if (t % 10 == 0 && t >= 10) begin
                r  = ((t / 10) - 1) % 4;
                ex = (16'h1000 * 16'(r + 1)) ^ 16'h5A5A;
                checks++; if (resp_v !== 1'b1 || resp_id !== 2'(r) || resp_x !== ex) begin
                    errors++; $display("FAIL rr_resp t%0d got v=%b id=%0d x=%h exp v=1 id=%0d x=%h", t, resp_v, resp_id, resp_x, r, ex); end
            end
            if (t == 15) begin
                checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_wait got %b exp 0000", gnt); end
            end
            step;
        end
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t <= 20; t++) begin
            req = (t <= 10) ? 4'b0010 : 4'b0000;
            #1;
            if (t == 0) begin
                checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_gnt0 got %b exp 0010", gnt); end
            end
            if (t == 10) begin
                checks++; if (resp_v !== 1'b1 || resp_id !== 2'd1) begin errors++; $display("FAIL b2b_resp got v=%b id=%0d exp v=1 id=1", resp_v, resp_id); end
                checks++; if (gnt !== 4'b0010 || ro_dv !== 1'b1) begin errors++; $display("FAIL b2b_reissue got gnt=%b v=%b exp 0010 1", gnt, ro_dv); end
            end
            if (t == 11) begin
                checks++; if (gnt !== 4'b0000 || resp_v !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL b2b_next got gnt=%b rv=%b busy=%b exp 0000 0 1", gnt, resp_v, busy); end
            end
            if (t == 20) begin
                checks++; if (resp_v !== 1'b1 || resp_id !== 2'd1 || err !== 1'b0) begin
                    errors++; $display("FAIL b2b_resp2 got v=%b id=%0d err=%b exp 1 1 0", resp_v, resp_id, err); end
            end
            step;
        end
    endtask

    task automatic test_err;
        for (int t = 0; t <= 11; t++) begin
            req    = (t == 0) ? 4'b0100 : 4'b0000;
            inject = (t == 5);
            #1;
            if (t == 5) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", err); end
            end
            if (t == 6) begin
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
            end
            if (t == 10) begin
                checks++; if (resp_v !== 1'b1 || resp_id !== 2'd2) begin errors++; $display("FAIL err_resp got v=%b id=%0d exp 1 2", resp_v, resp_id); end
            end
            step;
        end
        inject = 1'b0;
        for (int t = 0; t <= 11; t++) begin
            req = (t == 0) ? 4'b0001 : 4'b0000;
            #1;
            if (t == 0) begin
                checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL err_gnt2 got %b exp 0001", gnt); end
            end
            if (t == 10) begin
                checks++; if (resp_v !== 1'b1 || resp_id !== 2'd0 || resp_x !== 16'h4A5A) begin
                    errors++; $display("FAIL err_resp2 got v=%b id=%0d x=%h exp 1 0 4a5a", resp_v, resp_id, resp_x); end
            end
            if (t == 11) begin
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
            end
            step;
        end
    endtask

    task automatic test_reset_midop;
        int nresp;
        nresp = 0;
        for (int t = 0; t <= 16; t++) begin
            rst_n = (t != 4);
            if (t == 0)      req = 4'b0100;
            else if (t < 5)  req = 4'b1000;
            else if (t == 6) req = 4'b1111;
            else             req = 4'b0000;
            #1;
            if (t == 0) begin
                checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_gnt got %b exp 0100", gnt); end
            end
            if (t == 4) begin
                checks++; if (busy !== 1'b0 || ro_d_v !== 1'b0) begin errors++; $display("FAIL rmid_hold got busy=%b dv=%b exp 0 0", busy, ro_d_v); end
            end
            if (t == 5) begin
                checks++; if (busy !== 1'b0 || ro_d_v !== 1'b0 || ro_dv !== 1'b0 || gnt !== 4'b0000 || err !== 1'b0) begin
                    errors++; $display("FAIL rmid_zero got busy=%b dv=%b v=%b gnt=%b err=%b exp all 0", busy, ro_d_v, ro_dv, gnt, err); end
            end
            if (t >= 5 && t <= 15 && resp_v === 1'b1) nresp++;
            if (t == 6) begin
                checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_first got %b exp 0001", gnt); end
            end
            if (t == 16) begin
                checks++; if (resp_v !== 1'b1 || resp_id !== 2'd0) begin errors++; $display("FAIL rmid_resp got v=%b id=%0d exp 1 0", resp_v, resp_id); end
            end
            step;
        end
        checks++; if (nresp != 0) begin errors++; $display("FAIL rmid_noresp got %0d exp 0", nresp); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        test_reset;
        test_single;
        test_dstream;
        test_round_robin;
        test_back_to_back;
        test_err;
        test_reset_midop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
